// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Two-master arbiter for the MiniRISC data-memory bus. Master 0 is the CPU
// controller (its bus_grant ends the controller's load/store states), master 1
// is the DMA engine. Both share a single slave port. Ties in IDLE are broken
// round-robin. A per-access timeout forces a grant with bus_err when the slave
// never acknowledges, so every access is guaranteed to terminate.
//
// Ports
//   clk                    system clock, rising edge
//   rst                    synchronous reset, active low
//   m0_req/wr/rd           CPU request and strobes
//   m0_addr, m0_wdata      CPU address / write data
//   m0_grant, m0_rdata     CPU completion pulse and read data
//   m1_*                   same set for the DMA master
//   slv_wr, slv_rd         slave strobes
//   slv_addr, slv_wdata    slave address / write data
//   slv_rdata, slv_ack     slave read data and completion (may be combinational)
//   bus_err                one-cycle pulse with a timeout-forced grant
//   owner                  00 idle, 01 CPU, 10 DMA
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | bus free; arbitrate among pending requests
// ST_OWN_M0 | CPU owns the slave port until ack, timeout or withdrawal
// ST_OWN_M1 | DMA owns the slave port until ack, timeout or withdrawal
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic              m0_rd,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_grant,
   output logic [DATA_W-1:0] m0_rdata,

   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic              m1_rd,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_grant,
   output logic [DATA_W-1:0] m1_rdata,

   output logic              slv_wr,
   output logic              slv_rd,
   output logic [ADDR_W-1:0] slv_addr,
   output logic [DATA_W-1:0] slv_wdata,
   input  logic [DATA_W-1:0] slv_rdata,
   input  logic              slv_ack,

   output logic              bus_err,
   output logic [1:0]        owner
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_OWN_M0 = 2'b01,
      ST_OWN_M1 = 2'b10
   } state_t;

   // Counter value seen during the TIMEOUT-th owner cycle (counter starts at 0).
   localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_last;        // 0: M0 served last, 1: M1 served last
   logic       w_last_nxt;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_last  <= 1'b1;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_last  <= w_last_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_cnt;
      m0_grant    = 1'b0;
      m0_rdata    = '0;
      m1_grant    = 1'b0;
      m1_rdata    = '0;
      slv_wr      = 1'b0;
      slv_rd      = 1'b0;
      slv_addr    = '0;
      slv_wdata   = '0;
      bus_err     = 1'b0;
      owner       = 2'b00;

      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = 8'd0;
            // On a tie the master not served last wins.
            if (m0_req && (!m1_req || r_last)) begin
               w_state_nxt = ST_OWN_M0;
            end else if (m1_req) begin
               w_state_nxt = ST_OWN_M1;
            end
         end

         ST_OWN_M0: begin
            owner     = 2'b01;
            slv_addr  = m0_addr;
            slv_wdata = m0_wdata;
            slv_wr    = m0_wr & m0_req;
            slv_rd    = m0_rd & m0_req;
            if (!m0_req) begin
               // Withdrawn request: abort silently, arbitration history untouched.
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = 8'd0;
            end else if (slv_ack) begin
               m0_grant    = 1'b1;
               m0_rdata    = slv_rdata;
               w_state_nxt = ST_IDLE;
               w_last_nxt  = 1'b0;
               w_cnt_nxt   = 8'd0;
            end else if (r_cnt == LP_CNT_LAST) begin
               m0_grant    = 1'b1;
               bus_err     = 1'b1;
               w_state_nxt = ST_IDLE;
               w_last_nxt  = 1'b0;
               w_cnt_nxt   = 8'd0;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end

         ST_OWN_M1: begin
            owner     = 2'b10;
            slv_addr  = m1_addr;
            slv_wdata = m1_wdata;
            slv_wr    = m1_wr & m1_req;
            slv_rd    = m1_rd & m1_req;
            if (!m1_req) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = 8'd0;
            end else if (slv_ack) begin
               m1_grant    = 1'b1;
               m1_rdata    = slv_rdata;
               w_state_nxt = ST_IDLE;
               w_last_nxt  = 1'b1;
               w_cnt_nxt   = 8'd0;
            end else if (r_cnt == LP_CNT_LAST) begin
               m1_grant    = 1'b1;
               bus_err     = 1'b1;
               w_state_nxt = ST_IDLE;
               w_last_nxt  = 1'b1;
               w_cnt_nxt   = 8'd0;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

   logic       clk;
   logic       rst;
   logic       m0_req, m0_wr, m0_rd;
   logic [7:0] m0_addr, m0_wdata, m0_rdata;
   logic       m0_grant;
   logic       m1_req, m1_wr, m1_rd;
   logic [7:0] m1_addr, m1_wdata, m1_rdata;
   logic       m1_grant;
   logic       slv_wr, slv_rd, slv_ack;
   logic [7:0] slv_addr, slv_wdata, slv_rdata;
   logic       bus_err;
   logic [1:0] owner;

   mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (m0_req),
      .m0_wr     (m0_wr),
      .m0_rd     (m0_rd),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_grant  (m0_grant),
      .m0_rdata  (m0_rdata),
      .m1_req    (m1_req),
      .m1_wr     (m1_wr),
      .m1_rd     (m1_rd),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_grant  (m1_grant),
      .m1_rdata  (m1_rdata),
      .slv_wr    (slv_wr),
      .slv_rd    (slv_rd),
      .slv_addr  (slv_addr),
      .slv_wdata (slv_wdata),
      .slv_rdata (slv_rdata),
      .slv_ack   (slv_ack),
      .bus_err   (bus_err),
      .owner     (owner)
   );

   typedef struct {
      logic       m;
      logic [7:0] rdata;
      logic       err;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every grant pulse pops the oldest expectation.
   exp_t       mon_e;
   logic       mon_m;
   logic [7:0] mon_rd;
   always @(negedge clk) begin
      if (m0_grant === 1'b1 || m1_grant === 1'b1) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_grant: cycle %0d m0_grant=%b m1_grant=%b, required no grant",
                     cyc, m0_grant, m1_grant);
         end else begin
            mon_e  = sb.pop_front();
            mon_m  = m1_grant;
            mon_rd = m1_grant ? m1_rdata : m0_rdata;
            if ((m0_grant & m1_grant) !== 1'b0 || mon_m !== mon_e.m || mon_rd !== mon_e.rdata ||
                bus_err !== mon_e.err || cyc !== mon_e.cyc) begin
               n_err++;
               $display("FAIL grant: got cyc=%0d m=%b both=%b rdata=%h err=%b, required cyc=%0d m=%b rdata=%h err=%b",
                        cyc, mon_m, m0_grant & m1_grant, mon_rd, bus_err,
                        mon_e.cyc, mon_e.m, mon_e.rdata, mon_e.err);
            end
         end
      end else if (bus_err !== 1'b0) begin
         n_vec++;
         n_err++;
         $display("FAIL err_without_grant: cycle %0d bus_err=%b, required 0", cyc, bus_err);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      m0_req = 0; m0_wr = 0; m0_rd = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_wr = 0; m1_rd = 0; m1_addr = 0; m1_wdata = 0;
      slv_ack = 0; slv_rdata = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      m0_req = 1'b1; m0_rd = 1'b1; m0_addr = 8'h33;
      step();
      step();
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b00) begin
         n_err++; $display("FAIL reset_owner: got %b, required 00", owner);
      end
      n_vec++;
      if ({m0_grant, m1_grant, bus_err, slv_wr, slv_rd} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_strobes: got %b, required 00000", {m0_grant, m1_grant, bus_err, slv_wr, slv_rd});
      end
      n_vec++;
      if ({slv_addr, slv_wdata, m0_rdata, m1_rdata} !== 32'h0) begin
         n_err++;
         $display("FAIL reset_buses: got %h, required 0", {slv_addr, slv_wdata, m0_rdata, m1_rdata});
      end
      step();
      clear_inputs();
      rst = 1'b1;
   endtask

   task automatic test_single_read();
      int c0;
      step();
      c0 = cyc;
      m0_req = 1; m0_rd = 1; m0_addr = 8'h10;
      sb.push_back('{1'b0, 8'hA5, 1'b0, c0 + 1});
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b00 || slv_rd !== 1'b0) begin
         n_err++; $display("FAIL read_idle: owner=%b slv_rd=%b, required 00/0", owner, slv_rd);
      end
      step();
      slv_ack = 1; slv_rdata = 8'hA5;
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b01 || slv_rd !== 1'b1 || slv_wr !== 1'b0 || slv_addr !== 8'h10) begin
         n_err++;
         $display("FAIL read_own: owner=%b rd=%b wr=%b addr=%h, required 01/1/0/10", owner, slv_rd, slv_wr, slv_addr);
      end
      step();
      clear_inputs();
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b00) begin
         n_err++; $display("FAIL read_back_idle: owner=%b, required 00", owner);
      end
   endtask

   task automatic test_round_robin();
      int c0;
      logic [1:0] exp_own [8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      c0 = cyc;
      m0_req = 1; m0_rd = 1; m0_addr = 8'h21;
      m1_req = 1; m1_rd = 1; m1_addr = 8'h42;
      slv_ack = 1; slv_rdata = 8'h5A;
      sb.push_back('{1'b0, 8'h5A, 1'b0, c0 + 1});
      sb.push_back('{1'b1, 8'h5A, 1'b0, c0 + 3});
      sb.push_back('{1'b0, 8'h5A, 1'b0, c0 + 5});
      sb.push_back('{1'b1, 8'h5A, 1'b0, c0 + 7});
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_vec++;
         if (owner !== exp_own[i]) begin
            n_err++; $display("FAIL rr_owner[%0d]: got %b, required %b", i, owner, exp_own[i]);
         end
         if (exp_own[i] != 2'b00) begin
            n_vec++;
            if (slv_addr !== ((exp_own[i] == 2'b01) ? 8'h21 : 8'h42)) begin
               n_err++; $display("FAIL rr_addr[%0d]: got %h", i, slv_addr);
            end
         end
         step();
      end
      clear_inputs();
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b00) begin
         n_err++; $display("FAIL rr_end_idle: owner=%b, required 00", owner);
      end
   endtask

   task automatic test_delayed_write();
      int c0;
      step();
      c0 = cyc;
      m1_req = 1; m1_wr = 1; m1_addr = 8'h80; m1_wdata = 8'h3C;
      slv_rdata = 8'h99;
      sb.push_back('{1'b1, 8'h99, 1'b0, c0 + 3});
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b00 || slv_wr !== 1'b0) begin
         n_err++; $display("FAIL wr_idle: owner=%b slv_wr=%b, required 00/0", owner, slv_wr);
      end
      for (int k = 1; k <= 3; k++) begin
         step();
         if (k == 3) slv_ack = 1;
         @(negedge clk);
         n_vec++;
         if (owner !== 2'b10 || slv_wr !== 1'b1 || slv_rd !== 1'b0 || slv_wdata !== 8'h3C ||
             slv_addr !== 8'h80 || m0_grant !== 1'b0 || m0_rdata !== 8'h00) begin
            n_err++;
            $display("FAIL wr_hold[%0d]: owner=%b wr=%b rd=%b wdata=%h addr=%h m0g=%b m0rd=%h, required 10/1/0/3c/80/0/00",
                     k, owner, slv_wr, slv_rd, slv_wdata, slv_addr, m0_grant, m0_rdata);
         end
      end
      step();
      clear_inputs();
   endtask

   task automatic test_timeout();
      int c0;
      step();
      c0 = cyc;
      m0_req = 1; m0_rd = 1; m0_addr = 8'h44;
      slv_rdata = 8'hEE;
      sb.push_back('{1'b0, 8'h00, 1'b1, c0 + 15});
      for (int k = 1; k <= 15; k++) begin
         step();
         @(negedge clk);
         n_vec++;
         if (owner !== 2'b01 || slv_rd !== 1'b1) begin
            n_err++; $display("FAIL tmo_wait[%0d]: owner=%b slv_rd=%b, required 01/1", k, owner, slv_rd);
         end
      end
      step();
      clear_inputs();
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b00) begin
         n_err++; $display("FAIL tmo_idle: owner=%b, required 00", owner);
      end
   endtask

   task automatic test_abort();
      int c;
      // CPU withdraws on its 2nd owner cycle
      step();
      m0_req = 1; m0_wr = 1; m0_addr = 8'h55; m0_wdata = 8'h66;
      step();
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b01 || slv_wr !== 1'b1) begin
         n_err++; $display("FAIL abort_own: owner=%b slv_wr=%b, required 01/1", owner, slv_wr);
      end
      step();
      m0_req = 0;
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b01 || slv_wr !== 1'b0) begin
         n_err++; $display("FAIL abort_drop: owner=%b slv_wr=%b, required 01/0", owner, slv_wr);
      end
      step();
      clear_inputs();
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b00) begin
         n_err++; $display("FAIL abort_idle: owner=%b, required 00", owner);
      end
      // DMA alone, then a tie must go to the CPU
      step();
      c = cyc;
      m1_req = 1; m1_rd = 1; m1_addr = 8'h77;
      sb.push_back('{1'b1, 8'h31, 1'b0, c + 1});
      step();
      slv_ack = 1; slv_rdata = 8'h31;
      step();
      clear_inputs();
      step();
      c = cyc;
      m0_req = 1; m0_rd = 1; m1_req = 1; m1_rd = 1;
      slv_ack = 1; slv_rdata = 8'h13;
      sb.push_back('{1'b0, 8'h13, 1'b0, c + 1});
      step();
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b01) begin
         n_err++; $display("FAIL abort_tie_m0: owner=%b, required 01", owner);
      end
      step();
      clear_inputs();
      // DMA aborts; CPU was served last, so the next tie goes to the DMA
      step();
      m1_req = 1; m1_rd = 1;
      step();
      m1_req = 0;
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b10 || m1_grant !== 1'b0) begin
         n_err++; $display("FAIL abort_m1: owner=%b m1_grant=%b, required 10/0", owner, m1_grant);
      end
      step();
      clear_inputs();
      step();
      c = cyc;
      m0_req = 1; m0_rd = 1; m1_req = 1; m1_rd = 1;
      slv_ack = 1; slv_rdata = 8'h24;
      sb.push_back('{1'b1, 8'h24, 1'b0, c + 1});
      step();
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b10) begin
         n_err++; $display("FAIL abort_tie_m1: owner=%b, required 10", owner);
      end
      step();
      clear_inputs();
   endtask

   task automatic test_rst_mid_wait();
      int c0;
      // CPU served last, so only a reset of the history gives the CPU the next tie
      step();
      c0 = cyc;
      m0_req = 1; m0_rd = 1; m0_addr = 8'h01;
      slv_ack = 1; slv_rdata = 8'h0F;
      sb.push_back('{1'b0, 8'h0F, 1'b0, c0 + 1});
      step();
      step();
      clear_inputs();
      m1_req = 1; m1_wr = 1; m1_addr = 8'h90; m1_wdata = 8'hAB;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b10 || slv_wr !== 1'b1) begin
         n_err++; $display("FAIL rstw_wait: owner=%b slv_wr=%b, required 10/1", owner, slv_wr);
      end
      step();
      rst = 1'b1;
      m0_req = 1; m0_rd = 1; m0_addr = 8'h03;
      slv_ack = 1; slv_rdata = 8'h3E;
      sb.push_back('{1'b0, 8'h3E, 1'b0, c0 + 6});
      sb.push_back('{1'b1, 8'h3E, 1'b0, c0 + 8});
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b00 || slv_wr !== 1'b0) begin
         n_err++; $display("FAIL rstw_idle: owner=%b slv_wr=%b, required 00/0", owner, slv_wr);
      end
      step();
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b01) begin
         n_err++; $display("FAIL rstw_tie: owner=%b, required 01", owner);
      end
      step();
      m0_req = 0; m0_rd = 0;
      step();
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b10 || slv_wdata !== 8'hAB) begin
         n_err++; $display("FAIL rstw_m1: owner=%b wdata=%h, required 10/ab", owner, slv_wdata);
      end
      step();
      clear_inputs();
   endtask

   initial begin
      rst = 1'b0;
      clear_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_delayed_write();
      test_timeout();
      test_abort();
      test_rst_mid_wait();
      step();
      step();
      n_vec++;
      if (sb.size() != 0) begin
         n_err++; $display("FAIL missing_grants: %0d expected grants never seen, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter for the MiniRISC data-memory bus. It sits directly downstream of the CPU controller and consumes its `bus_req`, `data_mem_wr` and `data_mem_rd` strobes. It returns the `bus_grant` that terminates the controller's load and store states. A second master (DMA) shares the same slave port, and a timeout counter guarantees that every access terminates even if the slave never acknowledges.

## Interface
Parameters:
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.
- `TIMEOUT`, 15: maximum cycles in an owner state without `slv_ack` before a forced error termination. Legal range is 1..255.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `m0_req`  in  1  CPU bus request (controller `bus_req`).
- `m0_wr`, `m0_rd`  in  1 each  CPU write/read strobes.
- `m0_addr`  in  ADDR_W  CPU address.
- `m0_wdata`  in  DATA_W  CPU write data.
- `m0_grant`  out  1  CPU access completes this cycle (controller `bus_grant`).
- `m0_rdata`  out  DATA_W  CPU read data, valid when `m0_grant`=1.
- `m1_req`, `m1_wr`, `m1_rd`, `m1_addr`, `m1_wdata`, `m1_grant`, `m1_rdata`: same meanings for the DMA master.
- `slv_wr`, `slv_rd`  out  1 each  slave strobes.
- `slv_addr`  out  ADDR_W  slave address.
- `slv_wdata`  out  DATA_W  slave write data.
- `slv_rdata`  in  DATA_W  slave read data.
- `slv_ack`  in  1  slave completes the access this cycle (combinational path allowed).
- `bus_err`  out  1  one-cycle pulse coinciding with a timeout-forced grant.
- `owner`  out  2  bus owner: 00 = idle, 01 = M0, 10 = M1.

## Operation
- FSM states: IDLE, OWN_M0, OWN_M1. Reset (`rst`=0 at a clock edge) forces IDLE from any state, including mid-access.
- IDLE:
  - No request: stay in IDLE.
  - One requester: go to that master's owner state.
  - Both requesting: round-robin. The master not served last wins.
  - `last` register resets to M1, so the CPU wins the first tie.
- OWN_Mx, slave side:
  - `slv_*` driven from master x.
  - `slv_wr` = `mx_wr` & `mx_req`; `slv_rd` = `mx_rd` & `mx_req`.
- OWN_Mx, normal completion (`slv_ack`=1):
  - `mx_grant`=1 combinationally; `mx_rdata` = `slv_rdata`.
  - Next state IDLE; `last` := x; timeout counter := 0.
- OWN_Mx, waiting (`slv_ack`=0):
  - Counter increments.
  - When the counter equals TIMEOUT-1 and there is still no ack: `mx_grant`=1, `bus_err`=1, `mx_rdata`=0, slave strobes still asserted.
  - Next state IDLE; `last` := x.
- OWN_Mx, request withdrawn (`mx_req`=0 before grant): abort. Next state IDLE, no grant, no error, counter cleared, `last` unchanged.
- Non-owner master: grant=0 and rdata=0 at all times.
- IDLE outputs: all `slv_*` outputs 0; both grants 0; both rdata 0; `bus_err`=0.
- Illegal state encodings recover to IDLE on the next edge.
- A master whose `wr` and `rd` are both 1 is passed through unchanged; the slave defines that behaviour.
- Counter width is 8 bits. It never wraps because it is cleared on every exit from an owner state.

## Timing
- Reset values: state IDLE, `owner`=00, `last`=M1, counter 0, all outputs 0.
- Arbitration latency: request seen in IDLE at edge N. Owner state from edge N+1. Earliest grant is in cycle N+1 (same cycle as `slv_ack`).
- Minimum access time: 2 cycles (IDLE + owner cycle). Back-to-back accesses by the same master take 2 cycles each.
- Round-robin alternation under continuous dual requests: M0, M1, M0, ... with one IDLE cycle between grants.
- Timeout: grant with `bus_err` in the TIMEOUT-th cycle of the owner state. TIMEOUT=1 means any owner cycle without an ack errors immediately.
- Grants are single-cycle pulses. A master holds `req`, address and data stable until it sees its grant. After the grant, that master's `req` is ignored until the FSM has passed through IDLE.
- Reset asserted in a grant cycle: the combinational grant still shows for that cycle; state is IDLE afterwards.

## Test plan
- After reset, M0 read of addr 0x10 with slave returning 0xA5 and `slv_ack` in the first owner cycle: `m0_grant`=1 and `m0_rdata`=0xA5 exactly 1 cycle after `req`; `owner` sequence 00, 01, 00.
- `m0_req` and `m1_req` both held high for 4 accesses, slave always acks: grant order M0, M1, M0, M1; grants on cycles 1, 3, 5, 7.
- M1 write of 0x3C to addr 0x80, `slv_ack` delayed 3 cycles: `slv_wr`=1 and `slv_wdata`=0x3C held for 3 cycles; `m1_grant` on the 3rd owner cycle; `bus_err`=0.
- TIMEOUT=15, slave never acks an M0 read: `m0_grant` and `bus_err` pulse together on the 15th owner cycle; `m0_rdata`=0; FSM returns to IDLE.
- M0 drops `req` on the 2nd owner cycle with no ack: no grant, no error, next state IDLE. A subsequent M1 request is granted normally, and `last` still selects M0 on the next tie.
- `rst`=0 for one cycle while in OWN_M1 mid-wait: next cycle `owner`=00, counter 0. After release, a tie is won by M0.
